// File: rtl/multicycle_controller.sv
// Purpose : control unit for a multicycle RV32I subset (lw, sw, R-type, I-type ALU, jal, beq).
// Latency : outputs are combinational from the registered state; one state step per clock.
// Backpressure: none; the FSM advances every cycle and reset abandons the current instruction.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   op, funct3, funct7b5 - instruction fields used for sequencing and ALU decode
//   zero                - ALU zero flag, qualifies the branch PC write in the same cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite - datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc          - datapath mux selects
//   ALUControl          - ALU operation
//   illegal             - one-cycle pulse in Decode for an unsupported opcode
//   state               - current FSM encoding, for debug
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t     state_q;
    state_t     state_d;

    // Raw per-state controls before reset gating and branch qualification.
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       op_supported;

    assign state = state_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        op_supported = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH: op_supported = 1'b1;
            default: op_supported = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            // Encodings 11-15 are unused and recover to Fetch.
            default:    state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs per state
    // ------------------------------------------------------------------
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: begin
                pc_update = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate format decode, independent of state
    // ------------------------------------------------------------------
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decoder. Subtract for funct3=000 only for R-type (op[5]) with funct7b5,
    // so addi with a set Instr[30] still adds.
    // ------------------------------------------------------------------
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // ------------------------------------------------------------------
    // Output assembly. Reset gates every write enable and the illegal pulse
    // immediately, whatever state the register still holds.
    // ------------------------------------------------------------------
    always_comb begin
        AdrSrc    = adr_src;
        ResultSrc = result_src;
        ALUSrcA   = alu_src_a;
        ALUSrcB   = alu_src_b;
        PCWrite   = pc_update | (branch & zero);
        MemWrite  = mem_write;
        IRWrite   = ir_write;
        RegWrite  = reg_write;
        illegal   = (state_q == S_DECODE) && !op_supported;
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule
